spw_link_fsm_param: RTL and testbench

Parametrised SpaceWire link-interface state machine (ECSS-E-ST-50-12C §8.5) for the next-generation codec. It sits between the receiver and transmitter: it consumes receiver status strobes, drives receiver reset and transmitter enable/NULL/FCT requests, and reports link state. Compared with the first-generation FSM, it adds:
- parametrised timeouts;
- a gotNULL latch;
- a true first-bit-armed disconnect detector;
- a bounded retry counter with link-failed lockout;
- optional error statistics.

---
 rtl/spw_link_pkg.sv | 37 +++
 rtl/spw_disc_detect.sv | 46 ++++
 rtl/spw_link_fsm_param.sv | 196 +++++++++++++++++++
 tb/tb_spw_link_fsm_param.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spw_link_pkg.sv
// rtl/spw_link_pkg.sv - shared state codes, err_cause bit indices and default timing for the SpaceWire link FSM
package spw_link_pkg;

  // Link-interface state codes; codes 6 and 7 are illegal and recover to ERROR_RESET.
  typedef enum logic [2:0] {
    ST_ERROR_RESET = 3'd0,
    ST_ERROR_WAIT  = 3'd1,
    ST_READY       = 3'd2,
    ST_STARTED     = 3'd3,
    ST_CONNECTING  = 3'd4,
    ST_RUN         = 3'd5
  } link_state_e;

  // Bit positions inside err_cause ({disc, credit, rx_error, protocol}).
  localparam int ERR_BIT_PROTO  = 0;
  localparam int ERR_BIT_RXERR  = 1;
  localparam int ERR_BIT_CREDIT = 2;
  localparam int ERR_BIT_DISC   = 3;

  // Default timing for a 100 MHz pclk.
  localparam int T6U4_CYC_DEF  = 640;
  localparam int T12U8_CYC_DEF = 1280;
  localparam int DISC_CYC_DEF  = 85;

  // Assemble a one-hot-per-cause vector from the individual error sources.
  function automatic logic [3:0] err_cause_vec(input logic disc, input logic credit,
                                               input logic rx_err, input logic proto);
    logic [3:0] v;
    v                 = '0;
    v[ERR_BIT_DISC]   = disc;
    v[ERR_BIT_CREDIT] = credit;
    v[ERR_BIT_RXERR]  = rx_err;
    v[ERR_BIT_PROTO]  = proto;
    return v;
  endfunction

endpackage

// File: rtl/spw_disc_detect.sv
// rtl/spw_disc_detect.sv - first-bit-armed disconnect counter for the SpaceWire link FSM
module spw_disc_detect #(
  parameter int DISC_CYC = 85,
  parameter int CNT_W    = 12
) (
  input  logic pclk,
  input  logic reset,
  input  logic got_bit,
  input  logic clear,
  output logic disc
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DISC_CYC - 1);

  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Arm on the first bit, restart the gap count on every bit, hold once the limit is reached.
  always_comb begin
    armed_d = armed_q;
    cnt_d   = cnt_q;
    if (clear) begin
      armed_d = 1'b0;
      cnt_d   = '0;
    end else if (got_bit) begin
      armed_d = 1'b1;
      cnt_d   = '0;
    end else if (armed_q && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and arm flag registers.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

  assign disc = armed_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/spw_link_fsm_param.sv
// rtl/spw_link_fsm_param.sv - parametrised SpaceWire link-interface FSM; define SPW_LINK_ERRSTAT_EN for error statistics
module spw_link_fsm_param
  import spw_link_pkg::*;
#(
  parameter int T6U4_CYC  = T6U4_CYC_DEF,
  parameter int T12U8_CYC = T12U8_CYC_DEF,
  parameter int DISC_CYC  = DISC_CYC_DEF,
  parameter int CNT_W     = 12,
  parameter int RETRY_MAX = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 pclk,
  input  logic                 reset,
  input  logic                 auto_start,
  input  logic                 link_start,
  input  logic                 link_disable,
  input  logic                 rx_error,
  input  logic                 rx_credit_error,
  input  logic                 rx_got_bit,
  input  logic                 rx_got_null,
  input  logic                 rx_got_nchar,
  input  logic                 rx_got_time_code,
  input  logic                 rx_got_fct,
  input  logic                 clr_err_stat,
  output logic                 rx_resetn,
  output logic                 enable_tx,
  output logic                 send_null_tx,
  output logic                 send_fct_tx,
  output logic [2:0]           link_state,
  output logic                 link_up,
  output logic [3:0]           retry_cnt,
  output logic                 link_failed,
  output logic [3:0]           err_cause,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] T6_LAST  = CNT_W'(T6U4_CYC - 1);
  localparam logic [CNT_W-1:0] T12_LAST = CNT_W'(T12U8_CYC - 1);
  // The retry counter saturates at 15, so any limit above that can never be reached.
  localparam bit               RETRY_EN  = (RETRY_MAX != 0);
  localparam int               RETRY_CAP = (RETRY_MAX > 15) ? 16 : RETRY_MAX;
  localparam logic [4:0]       RETRY_LIM = 5'(RETRY_CAP);

  link_state_e      state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             got_null_q, got_null_d;
  logic [3:0]       retry_q, retry_d;

  logic disc;
  logic err_any;
  logic protocol;
  logic timeout;
  logic start_req;
  logic enter_err;
  logic failed;

  spw_disc_detect #(
    .DISC_CYC (DISC_CYC),
    .CNT_W    (CNT_W)
  ) u_disc (
    .pclk    (pclk),
    .reset   (reset),
    .got_bit (rx_got_bit),
    .clear   (state_q == ST_ERROR_RESET),
    .disc    (disc)
  );

  assign failed    = RETRY_EN && ({1'b0, retry_q} >= RETRY_LIM);
  assign err_any   = rx_error | disc;
  assign timeout   = (timer_q == T12_LAST);
  assign start_req = !link_disable && !failed && (link_start || (auto_start && got_null_q));

  // Characters that are not allowed in the current state count as protocol errors.
  always_comb begin
    protocol = 1'b0;
    case (state_q)
      ST_ERROR_WAIT, ST_READY, ST_STARTED: protocol = rx_got_fct | rx_got_nchar | rx_got_time_code;
      ST_CONNECTING:                       protocol = rx_got_nchar | rx_got_time_code;
      default:                             protocol = 1'b0;
    endcase
  end

  // Next-state rules; error exits are tested before forward progress in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ERROR_RESET: begin
        if (timer_q == T6_LAST) state_d = ST_ERROR_WAIT;
      end
      ST_ERROR_WAIT: begin
        if (err_any || protocol) state_d = ST_ERROR_RESET;
        else if (timeout)        state_d = ST_READY;
      end
      ST_READY: begin
        if (err_any || protocol) state_d = ST_ERROR_RESET;
        else if (start_req)      state_d = ST_STARTED;
      end
      ST_STARTED: begin
        if (err_any || protocol || timeout) state_d = ST_ERROR_RESET;
        else if (got_null_q)                state_d = ST_CONNECTING;
      end
      ST_CONNECTING: begin
        if (err_any || protocol || timeout) state_d = ST_ERROR_RESET;
        else if (rx_got_fct)                state_d = ST_RUN;
      end
      ST_RUN: begin
        if (err_any || rx_credit_error || link_disable) state_d = ST_ERROR_RESET;
      end
      default: state_d = ST_ERROR_RESET;
    endcase
  end

  assign enter_err = (state_d == ST_ERROR_RESET) && (state_q != ST_ERROR_RESET);

  // Shared dwell timer, gotNULL latch and failed-attempt counter.
  always_comb begin
    timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;

    got_null_d = got_null_q;
    if (state_q == ST_ERROR_RESET) got_null_d = 1'b0;
    else if (rx_got_null)          got_null_d = 1'b1;

    retry_d = retry_q;
    if (link_disable) begin
      retry_d = '0;
    end else if (enter_err && ((state_q == ST_STARTED) || (state_q == ST_CONNECTING))) begin
      if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
    end else if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
      retry_d = '0;
    end
  end

  // State, timer, latch and retry registers.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ERROR_RESET;
      timer_q    <= '0;
      got_null_q <= 1'b0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      got_null_q <= got_null_d;
      retry_q    <= retry_d;
    end
  end

`ifdef SPW_LINK_ERRSTAT_EN
  logic [3:0]           cause_q, cause_d;
  logic [3:0]           cause_now;
  logic [ERR_CNT_W-1:0] count_q, count_d;

  // Accumulate causes on every entry to ERROR_RESET; a clear in the same cycle loses.
  always_comb begin
    cause_now = err_cause_vec(disc, rx_credit_error && (state_q == ST_RUN), rx_error, protocol);
    cause_d   = cause_q;
    count_d   = count_q;
    if (enter_err) begin
      cause_d = cause_q | cause_now;
      if (count_q != '1) count_d = count_q + 1'b1;
    end else if (clr_err_stat) begin
      cause_d = '0;
      count_d = '0;
    end
  end

  // Statistics registers.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      cause_q <= '0;
      count_q <= '0;
    end else begin
      cause_q <= cause_d;
      count_q <= count_d;
    end
  end

  assign err_cause = cause_q;
  assign err_count = count_q;
`else
  logic errstat_unused;
  assign errstat_unused = clr_err_stat;
  assign err_cause      = '0;
  assign err_count      = '0;
`endif

  assign link_state   = state_q;
  assign rx_resetn    = (state_q != ST_ERROR_RESET);
  assign enable_tx    = (state_q >= ST_READY);
  assign send_null_tx = (state_q == ST_STARTED) || (state_q == ST_CONNECTING) || (state_q == ST_RUN);
  assign send_fct_tx  = (state_q == ST_CONNECTING) || (state_q == ST_RUN);
  assign link_up      = (state_q == ST_RUN);
  assign retry_cnt    = retry_q;
  assign link_failed  = failed;

endmodule

// File: tb/tb_spw_link_fsm_param.sv
// tb/tb_spw_link_fsm_param.sv - self-checking bench for spw_link_fsm_param against a behavioural link model
module tb_spw_link_fsm_param;

  localparam int T6   = 8;
  localparam int T12  = 16;
  localparam int DISC = 4;
  localparam int RMAX = 2;
  localparam int ECW  = 4;

`ifdef SPW_LINK_ERRSTAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic pclk = 1'b0;
  logic reset = 1'b1;
  logic auto_start = 0, link_start = 0, link_disable = 0;
  logic rx_error = 0, rx_credit_error = 0, rx_got_bit = 0, rx_got_null = 0;
  logic rx_got_nchar = 0, rx_got_time_code = 0, rx_got_fct = 0, clr_err_stat = 0;
  logic           rx_resetn, enable_tx, send_null_tx, send_fct_tx, link_up, link_failed;
  logic [2:0]     link_state;
  logic [3:0]     retry_cnt, err_cause;
  logic [ECW-1:0] err_count;

  int errors = 0;
  int checks = 0;

  spw_link_fsm_param #(
    .T6U4_CYC(T6), .T12U8_CYC(T12), .DISC_CYC(DISC), .CNT_W(12), .RETRY_MAX(RMAX), .ERR_CNT_W(ECW)
  ) dut (
    .pclk(pclk), .reset(reset), .auto_start(auto_start), .link_start(link_start),
    .link_disable(link_disable), .rx_error(rx_error), .rx_credit_error(rx_credit_error),
    .rx_got_bit(rx_got_bit), .rx_got_null(rx_got_null), .rx_got_nchar(rx_got_nchar),
    .rx_got_time_code(rx_got_time_code), .rx_got_fct(rx_got_fct), .clr_err_stat(clr_err_stat),
    .rx_resetn(rx_resetn), .enable_tx(enable_tx), .send_null_tx(send_null_tx),
    .send_fct_tx(send_fct_tx), .link_state(link_state), .link_up(link_up),
    .retry_cnt(retry_cnt), .link_failed(link_failed), .err_cause(err_cause), .err_count(err_count)
  );

  always #5 pclk = ~pclk;

  // Behavioural model: state as a plain number, time spent in it, and the cycle index of the last bit.
  int         m_state = 0, m_time = 0, m_last_bit = -1, m_cyc = 0, m_retry = 0, m_count = 0;
  bit         m_gotnull = 0;
  logic [3:0] m_cause = 0;

  function automatic bit m_failed();
    return (RMAX != 0) && (m_retry >= RMAX);
  endfunction

  task automatic model_reset();
    m_state = 0; m_time = 0; m_last_bit = -1; m_gotnull = 0;
    m_retry = 0; m_count = 0; m_cause = 0;
  endtask

  task automatic model_step();
    int nxt;
    bit disc, err, prot, entry;
    logic [3:0] why;
    disc = (m_last_bit >= 0) && ((m_cyc - m_last_bit) >= DISC);
    err  = rx_error || disc;
    prot = 0;
    if (m_state inside {1, 2, 3}) prot = rx_got_fct || rx_got_nchar || rx_got_time_code;
    if (m_state == 4)             prot = rx_got_nchar || rx_got_time_code;
    nxt = m_state;
    case (m_state)
      0: if (m_time == T6 - 1) nxt = 1;
      1: if (err || prot) nxt = 0; else if (m_time == T12 - 1) nxt = 2;
      2: if (err || prot) nxt = 0;
         else if (!link_disable && !m_failed() && (link_start || (auto_start && m_gotnull))) nxt = 3;
      3: if (err || prot || m_time == T12 - 1) nxt = 0; else if (m_gotnull) nxt = 4;
      4: if (err || prot || m_time == T12 - 1) nxt = 0; else if (rx_got_fct) nxt = 5;
      default: if (err || rx_credit_error || link_disable) nxt = 0;
    endcase
    entry = (nxt == 0) && (m_state != 0);
    why   = {disc, rx_credit_error && (m_state == 5), rx_error, prot};
    if (entry) begin
      m_cause = m_cause | why;
      if (m_count < (1 << ECW) - 1) m_count++;
    end else if (clr_err_stat) begin
      m_cause = 0;
      m_count = 0;
    end
    if (link_disable) m_retry = 0;
    else if (entry && (m_state == 3 || m_state == 4)) m_retry = (m_retry < 15) ? m_retry + 1 : 15;
    else if (nxt == 5 && m_state != 5) m_retry = 0;
    if (m_state == 0) m_gotnull = 0; else if (rx_got_null) m_gotnull = 1;
    if (m_state == 0) m_last_bit = -1; else if (rx_got_bit) m_last_bit = m_cyc;
    m_time  = (nxt == m_state) ? m_time + 1 : 0;
    m_state = nxt;
    m_cyc++;
  endtask

  // Advance the model on the same events the DUT reacts to.
  always @(posedge pclk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  // Compare every DUT output against the model once per cycle, away from the active edge.
  always @(negedge pclk) begin
    logic [20:0] act_v, exp_v;
    act_v = {link_state, rx_resetn, enable_tx, send_null_tx, send_fct_tx, link_up,
             retry_cnt, link_failed, err_cause, err_count};
    exp_v = {3'(m_state), m_state != 0, m_state >= 2, m_state >= 3, m_state >= 4, m_state == 5,
             4'(m_retry), m_failed(), STAT ? m_cause : 4'h0, STAT ? ECW'(m_count) : ECW'(0)};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_compare t=%0t dut=%h model=%h (state dut %0d model %0d)",
               $time, act_v, exp_v, link_state, m_state);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    while (int'(link_state) != s && n < budget) begin
      @(negedge pclk);
      n++;
    end
    check(name, int'(link_state), s);
  endtask

  task automatic dwell(input int s, output int n);
    n = 0;
    while (int'(link_state) == s && n < 5000) begin
      n++;
      @(negedge pclk);
    end
  endtask

  function automatic int outs_packed();
    return int'({link_state, rx_resetn, enable_tx, send_null_tx, send_fct_tx, link_up,
                 retry_cnt, link_failed, err_cause, err_count});
  endfunction

  initial begin
    int n;
    int pre;
    link_start = 1; rx_got_bit = 1; rx_got_null = 1;
    repeat (3) @(negedge pclk);
    check("reset_outputs", outs_packed(), 0);

    // Bring-up with link_start, NULLs and continuous bits.
    reset = 0;
    dwell(0, n); check("error_reset_dwell", n, 8);
    dwell(1, n); check("error_wait_dwell", n, 16);
    check("ready_after_wait", int'(link_state), 2);
    dwell(2, n); check("ready_dwell", n, 1);
    dwell(3, n); check("started_dwell", n, 1);
    check("connecting", int'(link_state), 4);
    rx_got_fct = 1; @(negedge pclk); rx_got_fct = 0;
    check("run_state", int'(link_state), 5);
    check("link_up", int'(link_up), 1);

    // Bit starvation in RUN: ERROR_RESET appears in the 5th cycle after the last bit.
    repeat (3) @(negedge pclk);
    rx_got_bit = 0; n = 1;
    while (link_state != 3'd0 && n < 50) begin @(negedge pclk); n++; end
    check("disc_latency", n, 5);
    check("disc_cause", int'(err_cause), STAT ? 8 : 0);
    check("disc_count", int'(err_count), STAT ? 1 : 0);

    // auto_start only; a NULL seen in ERROR_WAIT lets READY advance at once.
    link_start = 0; auto_start = 1; rx_got_null = 0; rx_got_bit = 1;
    wait_state(1, 40, "auto_reach_wait");
    repeat (3) @(negedge pclk);
    rx_got_null = 1; @(negedge pclk); rx_got_null = 0;
    wait_state(2, 40, "auto_reach_ready");
    dwell(2, n); check("auto_ready_dwell", n, 1);
    check("auto_started", int'(link_state), 3);
    wait_state(4, 5, "auto_connecting");
    rx_got_fct = 1; @(negedge pclk); rx_got_fct = 0;
    check("auto_run", int'(link_state), 5);

    // Started timeouts, lockout and release by link_disable.
    link_disable = 1; @(negedge pclk); link_disable = 0;
    check("disable_exit", int'(link_state), 0);
    auto_start = 0; link_start = 1;
    wait_state(3, 60, "retry_started1");
    dwell(3, n); check("started_timeout", n, 16);
    check("retry_one", int'(retry_cnt), 1);
    check("not_failed", int'(link_failed), 0);
    wait_state(3, 60, "retry_started2");
    dwell(3, n);
    check("retry_two", int'(retry_cnt), 2);
    check("failed_set", int'(link_failed), 1);
    wait_state(2, 60, "lock_ready");
    repeat (20) @(negedge pclk);
    check("lock_hold_ready", int'(link_state), 2);
    link_disable = 1; @(negedge pclk);
    check("lock_cleared", int'(link_failed), 0);
    check("retry_cleared", int'(retry_cnt), 0);
    check("disable_holds_ready", int'(link_state), 2);
    link_disable = 0; @(negedge pclk);
    check("restart", int'(link_state), 3);

    // FCT together with rx_error in CONNECTING: the error wins.
    rx_got_null = 1; @(negedge pclk); rx_got_null = 0;
    wait_state(4, 5, "conn_for_err");
    pre = m_count;
    rx_got_fct = 1; rx_error = 1; @(negedge pclk); rx_got_fct = 0; rx_error = 0;
    check("fct_err_state", int'(link_state), 0);
    check("fct_err_count", int'(err_count), STAT ? pre + 1 : 0);
    check("fct_err_cause", int'(err_cause), STAT ? 10 : 0);
    check("fct_err_retry", int'(retry_cnt), 1);

    // Asynchronous reset while in RUN.
    rx_got_null = 1;
    wait_state(4, 60, "reset_conn");
    rx_got_fct = 1; @(negedge pclk); rx_got_fct = 0;
    check("reset_run", int'(link_state), 5);
    @(posedge pclk); #2; reset = 1; #1;
    check("async_reset_outputs", outs_packed(), 0);
    repeat (2) @(negedge pclk);
    reset = 0;

    // Randomised traffic, checked every cycle against the model.
    for (int i = 0; i < 6000; i++) begin
      @(negedge pclk);
      rx_got_bit       = ($urandom_range(99) < 93);
      rx_got_null      = ($urandom_range(99) < 10);
      rx_got_fct       = ($urandom_range(99) < 4);
      rx_got_nchar     = ($urandom_range(99) < 1);
      rx_got_time_code = ($urandom_range(199) < 1);
      rx_error         = ($urandom_range(199) < 1);
      rx_credit_error  = ($urandom_range(199) < 1);
      link_start       = ($urandom_range(99) < 40);
      auto_start       = ($urandom_range(99) < 60);
      link_disable     = ($urandom_range(99) < 2);
      clr_err_stat     = ($urandom_range(99) < 2);
    end
    @(negedge pclk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
